universal_shift_rx: RTL and testbench
=====================================

// Module: universal_shift_rx
// PURPOSE
//  Serial-in/parallel-out receiver at the far end of a universal shift register's serial link.
//  Assembles WIDTH serial bits into a word, either MSB-first (left-shift in) or LSB-first (right-shift in).
//  Presents each completed word through a one-entry valid/ready output buffer.
//  Flags overrun when a word completes while the buffer is still full.
// PARAMETERS
//  WIDTH  4  word width in bits (>=2); bit counter is $clog2(WIDTH) bits wide
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      asynchronous, active-low reset (rst==0 resets immediately)
//  si         in   1      serial data bit
//  si_valid   in   1      si carries a bit this cycle
//  dir        in   2      01=LSB-first (right shift), 10=MSB-first (left shift), 11=resync, 00=hold
//  qp         out  WIDTH  received word (output buffer)
//  qp_valid   out  1      qp holds an unconsumed word
//  qp_ready   in   1      consumer accepts qp this cycle
//  bit_cnt    out  clog2  bits collected in current word (0..WIDTH-1)
//  overrun    out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (rst==0, async): sh=0, bit_cnt=0, qp=0, qp_valid=0, overrun=0. Held while rst==0.
//  Shift step (si_valid==1 and dir is 01 or 10), per posedge:
//   dir==10: nxt={sh[WIDTH-2:0],si}; dir==01: nxt={si,sh[WIDTH-1:1]}.
//   If bit_cnt<WIDTH-1: sh<=nxt, bit_cnt<=bit_cnt+1.
//   If bit_cnt==WIDTH-1 (word complete): bit_cnt<=0 (wrap), sh<=0, nxt offered to buffer.
//  si_valid==0 or dir==00: sh and bit_cnt hold; si ignored.
//  dir==11 (resync): sh<=0, bit_cnt<=0, overrun<=0, regardless of si_valid.
//   qp/qp_valid are unaffected; a pop in the same cycle still completes.
//  dir may change mid-word: no resync; later bits use the new shift direction; bit_cnt continues.
//  Output buffer (priority order each cycle, with pop = qp_valid & qp_ready):
//   complete & (!qp_valid | pop): qp<=nxt, qp_valid<=1 (back-to-back, no bubble).
//   complete & qp_valid & !pop: word dropped, qp unchanged, overrun<=1.
//   pop & !complete: qp_valid<=0, qp holds its last value.
//  Latency: qp/qp_valid update at the same posedge that samples the last bit (visible next cycle).
//  overrun clears only on reset or dir==11. qp_ready is ignored while qp_valid==0.
//  Throughput: one word per WIDTH si_valid cycles; no internal stall, si is never backpressured.
// TESTING
//  T1 reset: drive rst=0 mid-word (bit_cnt=2) asynchronously -> all outputs 0 immediately, before the next clk edge.
//  T2 MSB-first: dir=10, si=1,0,1,1 on 4 valid cycles, qp_ready=1 -> qp=4'b1011, qp_valid pulses 1 cycle, bit_cnt 0,1,2,3,0.
//  T3 LSB-first: dir=01, si=1,0,1,1 -> qp=4'b1101; si_valid gaps of 3 cycles between bits -> same result.
//  T4 backpressure: qp_ready=0; send 4'b1011 then 4'b0110 (dir=10) -> qp stays 1011, overrun=1;
//     dir=11 for 1 cycle -> overrun=0, qp_valid=1 retained.
//  T5 simultaneous: qp_valid=1, qp_ready=1 on the cycle the 4th bit of 4'b0101 arrives -> qp=0101, qp_valid stays 1, overrun=0.
//  T6 resync/hold: 2 bits in, then dir=00 for 5 cycles -> bit_cnt=2 held; dir=11 -> bit_cnt=0;
//     next 4 bits 1,1,0,0 (dir=10) -> qp=4'b1100.

Source files
------------

// File: rtl/universal_shift_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH serial bits MSB- or LSB-first
// and hands each finished word to a one-entry valid/ready buffer with sticky overrun.
module universal_shift_rx #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_valid,
  input  logic [1:0]       dir,
  output logic [WIDTH-1:0] qp,
  output logic             qp_valid,
  input  logic             qp_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic [1:0] {
    D_HOLD   = 2'b00,
    D_LSB    = 2'b01,
    D_MSB    = 2'b10,
    D_RESYNC = 2'b11
  } dir_e;

  logic [WIDTH-1:0] sh, nxt;
  logic             shift, complete, pop, resync;

  assign resync   = (dir == D_RESYNC);
  assign shift    = si_valid & ((dir == D_LSB) | (dir == D_MSB));
  assign complete = shift & (bit_cnt == CW'(WIDTH-1));
  assign pop      = qp_valid & qp_ready;

  always_comb begin
    nxt = {si, sh[WIDTH-1:1]};
    if (dir == D_MSB) nxt = {sh[WIDTH-2:0], si};
  end

  // Shift register and bit counter; a completed word leaves sh cleared for the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (resync) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      if (complete) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else begin
        sh      <= nxt;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Output buffer: load wins over pop so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qp       <= '0;
      qp_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (complete && (!qp_valid || pop)) begin
        qp       <= nxt;
        qp_valid <= 1'b1;
      end else if (complete) begin
        overrun  <= 1'b1;
      end else if (pop) begin
        qp_valid <= 1'b0;
      end
      if (resync) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_universal_shift_rx.sv
// Scoreboard bench for universal_shift_rx: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted output word.
module tb_universal_shift_rx;

  localparam int WIDTH = 4;
  localparam int CW = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             si = 1'b0;
  logic             si_valid = 1'b0;
  logic [1:0]       dir = 2'b00;
  logic [WIDTH-1:0] qp;
  logic             qp_valid;
  logic             qp_ready = 1'b0;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  universal_shift_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .dir(dir),
    .qp(qp), .qp_valid(qp_valid), .qp_ready(qp_ready),
    .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge.
  task automatic step(input logic v, input logic b, input logic [1:0] d);
    si_valid = v;
    si       = b;
    dir      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic [1:0] d);
    for (int i = 0; i < WIDTH; i++)
      step(1'b1, (d == 2'b10) ? w[WIDTH-1-i] : w[i], d);
  endtask

  // Monitor: an accepted word is sampled on the negedge before the popping posedge.
  always @(negedge clk) begin
    if (rst && qp_valid && qp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none at %0t", qp, $time);
      end else begin
        chk("scoreboard_qp", qp, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // reset state
    #3;
    chk("reset_qp", qp, 0);
    chk("reset_qp_valid", qp_valid, 0);
    chk("reset_bit_cnt", bit_cnt, 0);
    chk("reset_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    // T1: async reset mid-word with a word parked in the buffer
    qp_ready = 1'b0;
    send_word(4'b1011, 2'b10);
    chk("t1_pre_qp", qp, 4'b1011);
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b10);
    chk("t1_pre_bit_cnt", bit_cnt, 2);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_qp", qp, 0);
    chk("t1_async_qp_valid", qp_valid, 0);
    chk("t1_async_bit_cnt", bit_cnt, 0);
    chk("t1_async_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    // T2: MSB-first, bit_cnt sequence 0,1,2,3 then 0
    qp_ready = 1'b1;
    exp_q.push_back(4'b1011);
    begin
      logic [WIDTH-1:0] w;
      w = 4'b1011;
      for (int i = 0; i < WIDTH; i++) begin
        chk("t2_bit_cnt", bit_cnt, i);
        step(1'b1, w[WIDTH-1-i], 2'b10);
      end
    end
    chk("t2_bit_cnt_wrap", bit_cnt, 0);
    chk("t2_qp_valid_set", qp_valid, 1);
    idle();
    chk("t2_qp_valid_pulse", qp_valid, 0);

    // T3: LSB-first back-to-back, then with 3-cycle gaps
    exp_q.push_back(4'b1101);
    send_word(4'b1101, 2'b01);
    idle();
    exp_q.push_back(4'b1101);
    begin
      logic [WIDTH-1:0] w;
      w = 4'b1101;
      for (int i = 0; i < WIDTH; i++) begin
        step(1'b1, w[i], 2'b01);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 2'b01);
        if (i == 1) chk("t3_gap_bit_cnt", bit_cnt, 2);
      end
    end
    idle();
    chk("t3_drained", qp_valid, 0);

    // T4: backpressure and overrun, cleared by resync
    qp_ready = 1'b0;
    exp_q.push_back(4'b1011);
    send_word(4'b1011, 2'b10);
    send_word(4'b0110, 2'b10);
    idle();
    chk("t4_qp_kept", qp, 4'b1011);
    chk("t4_overrun", overrun, 1);
    chk("t4_overrun_sticky", overrun, 1);
    step(1'b0, 1'b0, 2'b11);
    chk("t4_resync_overrun", overrun, 0);
    chk("t4_resync_qp_valid", qp_valid, 1);

    // T5: pop and load on the same edge
    exp_q.push_back(4'b0101);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b10);
    qp_ready = 1'b1;
    step(1'b1, 1'b1, 2'b10);
    chk("t5_qp", qp, 4'b0101);
    chk("t5_qp_valid", qp_valid, 1);
    chk("t5_overrun", overrun, 0);
    idle();
    chk("t5_drained", qp_valid, 0);

    // T6: hold then resync mid-word
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b10);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b00);
    chk("t6_hold_bit_cnt", bit_cnt, 2);
    step(1'b1, 1'b1, 2'b11);
    chk("t6_resync_bit_cnt", bit_cnt, 0);
    exp_q.push_back(4'b1100);
    send_word(4'b1100, 2'b10);
    chk("t6_qp", qp, 4'b1100);
    idle();
    idle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
